// File: rtl/xor3_bist.sv
// xor3_bist: self-test sequencer for the 3-input registered XOR test design.
// Drives every 3-bit vector onto gpio0..gpio2 for LOOPS passes, then checks
// gpio3 against the predicted parity LAT cycles later. Reports a saturating
// mismatch count, the first failing vector and a pass flag.
//
// Handshake: there is no valid/ready pair here. start is a request sampled
// only in IDLE or DONE (ignored in RUN and DRAIN). done is a level that holds
// until the next accepted start or reset. busy covers RUN and DRAIN.
module xor3_bist #(
    parameter int LAT   = 1,  // DUT latency from stim change to valid resp (>=1)
    parameter int LOOPS = 4,  // complete passes over the 8 vectors (>=1)
    parameter int ERR_W = 8   // width of the saturating error counter
) (
    input  logic             gclk,
    input  logic             reset,
    input  logic             start,
    output logic [2:0]       stim,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_err_vec,
    output logic             first_err_valid,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam int DRN_W  = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);
    localparam logic [DRN_W-1:0]  LAST_DRN  = DRN_W'(LAT - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t            state;
    logic [LOOP_W-1:0] loop_cnt;
    logic [DRN_W-1:0]  drain_cnt;

    // Expected-result pipeline: stage i holds the vector issued i+1 cycles ago.
    logic [LAT-1:0] pipe_valid;
    logic [LAT-1:0] pipe_exp;
    logic [2:0]     pipe_vec [LAT];

    logic           tail_valid;
    logic [2:0]     tail_vec;
    logic           tail_exp;
    logic           mismatch;
    logic           last_vec;

    assign tail_valid = pipe_valid[LAT-1];
    assign tail_vec   = pipe_vec[LAT-1];
    assign tail_exp   = pipe_exp[LAT-1];

    // Compare resp with the prediction for the vector issued LAT cycles ago.
    always_comb begin
        mismatch = 1'b0;
        if (tail_valid && (resp != tail_exp)) begin
            mismatch = 1'b1;
        end
    end

    // The final vector of the final pass is on stim this cycle.
    assign last_vec = (stim == 3'd7) && (loop_cnt == LAST_LOOP);

    // pass never asserts before the run completes.
    assign pass      = done && (err_count == '0);
    assign dbg_state = state;

    // Shift the issued vector and its parity down the expected pipeline.
    always_ff @(posedge gclk) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_exp   <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_vec[i] <= 3'd0;
            end
        end else begin
            pipe_valid[0] <= (state == RUN);
            pipe_vec[0]   <= stim;
            pipe_exp[0]   <= ^stim;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_vec[i]   <= pipe_vec[i-1];
                pipe_exp[i]   <= pipe_exp[i-1];
            end
        end
    end

    // Sequencer FSM with registered stimulus, status and error capture.
    always_ff @(posedge gclk) begin
        if (reset) begin
            state           <= IDLE;
            stim            <= 3'd0;
            loop_cnt        <= '0;
            drain_cnt       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= 3'd0;
            first_err_valid <= 1'b0;
        end else begin
            // Error capture; the tail is never valid in IDLE or DONE, so the
            // start-time clear below cannot collide with a live compare.
            if (mismatch) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (!first_err_valid) begin
                    first_err_vec   <= tail_vec;
                    first_err_valid <= 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    stim <= 3'd0;
                    if (start) begin
                        state           <= RUN;
                        loop_cnt        <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        err_count       <= '0;
                        first_err_vec   <= 3'd0;
                        first_err_valid <= 1'b0;
                    end
                end

                RUN: begin
                    if (last_vec) begin
                        state     <= DRAIN;
                        stim      <= 3'd0;
                        drain_cnt <= '0;
                    end else begin
                        stim <= stim + 3'd1;
                        if (stim == 3'd7) begin
                            loop_cnt <= loop_cnt + LOOP_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    stim <= 3'd0;
                    if (drain_cnt == LAST_DRN) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    stim  <= 3'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor3_bist.sv
// Bench for xor3_bist: three instances (LAT=1/ERR_W=8, LAT=1/ERR_W=4,
// LAT=3/ERR_W=8) share clock, reset and start; each has its own XOR model.
module tb_xor3_bist;

    logic gclk;
    logic reset;
    logic start;

    // Instance 0: LAT=1, ERR_W=8
    logic [2:0] stim0;
    logic       resp0, busy0, done0, pass0, fev_ok0;
    logic [7:0] err0;
    logic [2:0] fev0;
    logic [1:0] st0;

    // Instance S: LAT=1, ERR_W=4
    logic [2:0] stim_s;
    logic       resp_s, busy_s, done_s, pass_s, fev_ok_s;
    logic [3:0] err_s;
    logic [2:0] fev_s;
    logic [1:0] st_s;

    // Instance 3: LAT=3, ERR_W=8
    logic [2:0] stim3;
    logic       resp3, busy3, done3, pass3, fev_ok3;
    logic [7:0] err3;
    logic [2:0] fev3;
    logic [1:0] st3;

    // mode: 0 ideal, 1 stuck-at-0, 2 inverted (instances 0 and S)
    int   mode;
    // lat3_mode: 0 three-stage model, 1 single-stage model
    int   lat3_mode;

    logic r0 = 1'b0;
    logic rs = 1'b0;
    logic l3a = 1'b0, l3b = 1'b0, l3c = 1'b0;

    int checks;
    int errors;

    int   n0, ns, n3;
    bit   timed_out;
    logic first_done0;
    logic [7:0] first_err0;
    logic first_fev_ok0;
    logic [2:0] seq [64];

    xor3_bist #(.LAT(1), .LOOPS(4), .ERR_W(8)) u_dut (
        .gclk(gclk), .reset(reset), .start(start), .stim(stim0), .resp(resp0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_vec(fev0), .first_err_valid(fev_ok0), .dbg_state(st0)
    );

    xor3_bist #(.LAT(1), .LOOPS(4), .ERR_W(4)) u_sat (
        .gclk(gclk), .reset(reset), .start(start), .stim(stim_s), .resp(resp_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_err_vec(fev_s), .first_err_valid(fev_ok_s), .dbg_state(st_s)
    );

    xor3_bist #(.LAT(3), .LOOPS(4), .ERR_W(8)) u_lat3 (
        .gclk(gclk), .reset(reset), .start(start), .stim(stim3), .resp(resp3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_vec(fev3), .first_err_valid(fev_ok3), .dbg_state(st3)
    );

    // Clock and reset
    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // XOR DUT models
    always @(posedge gclk) begin
        r0  <= ^stim0;
        rs  <= ^stim_s;
        l3a <= ^stim3;
        l3b <= l3a;
        l3c <= l3b;
    end

    assign resp0  = (mode == 0) ? r0 : (mode == 1) ? 1'b0 : ~r0;
    assign resp_s = (mode == 0) ? rs : (mode == 1) ? 1'b0 : ~rs;
    assign resp3  = (lat3_mode == 0) ? l3c : l3a;

    // Driver: raise start for 'hold' cycles, then wait until every instance is done.
    task automatic run_test(input int hold);
        n0 = 0; ns = 0; n3 = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 64; k++) seq[k] = 3'd0;
        start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge gclk);
            if (c + 1 >= hold) start = 1'b0;
            if (c == 0) begin
                first_done0   = done0;
                first_err0    = err0;
                first_fev_ok0 = fev_ok0;
            end
            if (busy0) begin
                if (n0 < 64) seq[n0] = stim0;
                n0++;
            end
            if (busy_s) ns++;
            if (busy3) n3++;
            if (done0 && done_s && done3) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge gclk);
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st0); end
        checks++; if (stim0 !== 3'd0) begin errors++; $display("FAIL reset_stim: got %0d expected 0", stim0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass0); end
        checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err0); end
        checks++; if (fev0 !== 3'd0) begin errors++; $display("FAIL reset_fev: got %0d expected 0", fev0); end
        checks++; if (fev_ok0 !== 1'b0) begin errors++; $display("FAIL reset_fev_ok: got %b expected 0", fev_ok0); end
        reset = 1'b0;
        @(negedge gclk);
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", st0); end
    endtask

    task automatic test_ideal();
        mode = 0; lat3_mode = 0;
        run_test(1);
        checks++; if (timed_out) begin errors++; $display("FAIL ideal_timeout: got timeout expected done"); end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (seq[k] !== 3'(k % 8)) begin errors++; $display("FAIL ideal_seq[%0d]: got %0d expected %0d", k, seq[k], k % 8); end
        end
        checks++; if (seq[32] !== 3'd0) begin errors++; $display("FAIL ideal_drain_stim: got %0d expected 0", seq[32]); end
        checks++; if (n0 != 33) begin errors++; $display("FAIL ideal_busy: got %0d expected 33", n0); end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL ideal_done: got %b expected 1", done0); end
        checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL ideal_pass: got %b expected 1", pass0); end
        checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL ideal_err: got %0d expected 0", err0); end
        checks++; if (fev_ok0 !== 1'b0) begin errors++; $display("FAIL ideal_fev_ok: got %b expected 0", fev_ok0); end
        checks++; if (n3 != 35) begin errors++; $display("FAIL lat3_busy: got %0d expected 35", n3); end
        checks++; if (pass3 !== 1'b1) begin errors++; $display("FAIL lat3_pass: got %b expected 1", pass3); end
        // done is a level: hold a few idle cycles with start low
        repeat (3) @(negedge gclk);
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL done_level: got %b expected 1", done0); end
        checks++; if (stim0 !== 3'd0) begin errors++; $display("FAIL done_stim: got %0d expected 0", stim0); end
    endtask

    task automatic test_stuck0();
        mode = 1;
        run_test(1);
        // First cycle after a start from DONE
        checks++; if (first_done0 !== 1'b0) begin errors++; $display("FAIL restart_done_clear: got %b expected 0", first_done0); end
        checks++; if (first_err0 !== 8'd0) begin errors++; $display("FAIL restart_err_clear: got %0d expected 0", first_err0); end
        checks++; if (first_fev_ok0 !== 1'b0) begin errors++; $display("FAIL restart_fev_clear: got %b expected 0", first_fev_ok0); end
        checks++; if (timed_out) begin errors++; $display("FAIL stuck_timeout: got timeout expected done"); end
        checks++; if (n0 != 33) begin errors++; $display("FAIL stuck_busy: got %0d expected 33", n0); end
        checks++; if (err0 !== 8'd16) begin errors++; $display("FAIL stuck_err: got %0d expected 16", err0); end
        checks++; if (fev0 !== 3'd1) begin errors++; $display("FAIL stuck_fev: got %0d expected 1", fev0); end
        checks++; if (fev_ok0 !== 1'b1) begin errors++; $display("FAIL stuck_fev_ok: got %b expected 1", fev_ok0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b expected 0", pass0); end
        checks++; if (err_s !== 4'd15) begin errors++; $display("FAIL stuck_sat_err: got %0d expected 15", err_s); end
    endtask

    task automatic test_inverted();
        mode = 2;
        run_test(1);
        checks++; if (timed_out) begin errors++; $display("FAIL inv_timeout: got timeout expected done"); end
        checks++; if (err0 !== 8'd32) begin errors++; $display("FAIL inv_err: got %0d expected 32", err0); end
        checks++; if (fev0 !== 3'd0) begin errors++; $display("FAIL inv_fev: got %0d expected 0", fev0); end
        checks++; if (fev_ok0 !== 1'b1) begin errors++; $display("FAIL inv_fev_ok: got %b expected 1", fev_ok0); end
        checks++; if (err_s !== 4'd15) begin errors++; $display("FAIL inv_sat_err: got %0d expected 15", err_s); end
        checks++; if (pass_s !== 1'b0) begin errors++; $display("FAIL inv_sat_pass: got %b expected 0", pass_s); end
    endtask

    task automatic test_latency_mismatch();
        mode = 0; lat3_mode = 1;
        run_test(1);
        checks++; if (timed_out) begin errors++; $display("FAIL latmis_timeout: got timeout expected done"); end
        checks++; if (err3 === 8'd0) begin errors++; $display("FAIL latmis_err: got %0d expected nonzero", err3); end
        checks++; if (pass3 !== 1'b0) begin errors++; $display("FAIL latmis_pass: got %b expected 0", pass3); end
        checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL latmis_main_pass: got %b expected 1", pass0); end
        lat3_mode = 0;
    endtask

    task automatic test_reset_mid_run();
        mode = 1;
        start = 1'b1;
        @(negedge gclk);
        start = 1'b0;
        // Now in RUN cycle 0; advance to RUN cycle 9 (the 10th)
        repeat (9) @(negedge gclk);
        checks++; if (stim0 !== 3'd1) begin errors++; $display("FAIL mid_stim: got %0d expected 1", stim0); end
        checks++; if (err0 !== 8'd4) begin errors++; $display("FAIL mid_err: got %0d expected 4", err0); end
        reset = 1'b1;
        @(negedge gclk);
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", st0); end
        checks++; if (stim0 !== 3'd0) begin errors++; $display("FAIL mid_reset_stim: got %0d expected 0", stim0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy0); end
        checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL mid_reset_err: got %0d expected 0", err0); end
        checks++; if (fev_ok0 !== 1'b0) begin errors++; $display("FAIL mid_reset_fev_ok: got %b expected 0", fev_ok0); end
        reset = 1'b0;
        mode = 0;
        @(negedge gclk);
        run_test(1);
        checks++; if (timed_out) begin errors++; $display("FAIL rerun_timeout: got timeout expected done"); end
        checks++; if (n0 != 33) begin errors++; $display("FAIL rerun_busy: got %0d expected 33", n0); end
        checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL rerun_pass: got %b expected 1", pass0); end
        checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL rerun_err: got %0d expected 0", err0); end
    endtask

    task automatic test_start_held();
        mode = 0;
        run_test(20);
        checks++; if (timed_out) begin errors++; $display("FAIL held_timeout: got timeout expected done"); end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (seq[k] !== 3'(k % 8)) begin errors++; $display("FAIL held_seq[%0d]: got %0d expected %0d", k, seq[k], k % 8); end
        end
        checks++; if (n0 != 33) begin errors++; $display("FAIL held_busy: got %0d expected 33", n0); end
        checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL held_pass: got %b expected 1", pass0); end
        @(negedge gclk);
        checks++; if (st0 !== 2'd3) begin errors++; $display("FAIL held_stays_done: got %0d expected 3", st0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode = 0;
        lat3_mode = 0;
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_ideal();
        test_stuck0();
        test_inverted();
        test_latency_mismatch();
        test_reset_mid_run();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
